// File: rtl/qupls_fpu_wb.sv
// FPU writeback: buffers finished FPU results, merges copy-target bytes, drives
// register-file writes and ROB completion. Optional macro: QUPLS_FPU_WB_BYPASS_EN.
module qupls_fpu_wb #(
    parameter int DEP = 4,
    parameter int VW  = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            fpu_done,
    input  logic [4:0]      fpu_id,
    input  logic [10:0]     fpu_Rt,
    input  logic [6:0]      fpu_aRt,
    input  logic            fpu_aRtz,
    input  logic            fpu_qfext,
    input  logic [10:0]     fpu_Rt1,
    input  logic [6:0]      fpu_aRt1,
    input  logic            fpu_aRtz1,
    input  logic [VW-1:0]   fpu_res,
    input  logic [VW-1:0]   fpu_res1,
    input  logic [VW-1:0]   fpu_argT,
    input  logic [VW/8-1:0] fpu_cptgt,
    input  logic [7:0]      fpu_exc,
    output logic            fpu_stall,
    output logic            wr_v,
    output logic [10:0]     wr_Rt,
    output logic [6:0]      wr_aRt,
    output logic [VW-1:0]   wr_res,
    input  logic            wr_ack,
    output logic            done_v,
    output logic [4:0]      done_id,
    output logic [7:0]      done_exc,
    output logic            ovf
);

    localparam int AW = $clog2(DEP);
    localparam int NB = VW / 8;
    localparam logic [AW:0] DEPC = DEP[AW:0];

    typedef struct packed {
        logic [4:0]    id;
        logic [10:0]   Rt;
        logic [6:0]    aRt;
        logic          aRtz;
        logic          qfext;
        logic [10:0]   Rt1;
        logic [6:0]    aRt1;
        logic          aRtz1;
        logic [VW-1:0] res;
        logic [VW-1:0] res1;
        logic [7:0]    exc;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WR0, WR1} state_t;

    state_t        state, nextState;
    entry_t        mem [DEP];
    entry_t        inEnt, headEnt, cur;
    logic [VW-1:0] merged;
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0]   count;
    logic          empty, full, push, pop, bypass;
    logic          wrSup, step, finish;

    always_comb begin
        merged = '0;
        for (int unsigned i = 0; i < NB; i++)
            merged[i*8 +: 8] = fpu_cptgt[i] ? fpu_argT[i*8 +: 8] : fpu_res[i*8 +: 8];
    end

    assign inEnt = '{id: fpu_id, Rt: fpu_Rt, aRt: fpu_aRt, aRtz: fpu_aRtz,
                     qfext: fpu_qfext, Rt1: fpu_Rt1, aRt1: fpu_aRt1, aRtz1: fpu_aRtz1,
                     res: merged, res1: fpu_res1, exc: fpu_exc};

    assign headEnt   = mem[rdPtr];
    assign empty     = (count == '0);
    assign full      = (count == DEPC);
    assign fpu_stall = full;

`ifdef QUPLS_FPU_WB_BYPASS_EN
    // Only an empty FIFO may be skipped, so result order is never disturbed.
    assign bypass = fpu_done & empty & (state == IDLE) & ~flush;
`else
    assign bypass = 1'b0;
`endif

    assign push = fpu_done & ~flush & ~full & ~bypass;
    assign pop  = (state == IDLE) & ~empty & ~flush;

    assign wr_v   = ((state == WR0) & ~cur.aRtz) | ((state == WR1) & ~cur.aRtz1);
    assign wrSup  = ((state == WR0) & cur.aRtz) | ((state == WR1) & cur.aRtz1);
    assign step   = (wr_v & wr_ack) | wrSup;
    assign wr_Rt  = (state == WR1) ? cur.Rt1  : cur.Rt;
    assign wr_aRt = (state == WR1) ? cur.aRt1 : cur.aRt;
    assign wr_res = (state == WR1) ? cur.res1 : cur.res;

    always_comb begin
        nextState = state;
        finish    = 1'b0;
        case (state)
            IDLE: if (pop || bypass) nextState = WR0;
            WR0: if (step) begin
                if (cur.qfext) nextState = WR1;
                else begin
                    finish    = 1'b1;
                    nextState = IDLE;
                end
            end
            WR1: if (step) begin
                finish    = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        // An ack landing in a flush cycle is swallowed along with the op.
        if (flush) begin
            nextState = IDLE;
            finish    = 1'b0;
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wrPtr] <= inEnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            cur      <= '0;
            done_v   <= 1'b0;
            done_id  <= '0;
            done_exc <= '0;
        end else begin
            state  <= nextState;
            done_v <= finish;
            if (finish) begin
                done_id  <= cur.id;
                done_exc <= cur.exc;
            end
            if (fpu_done && full && !flush) ovf <= 1'b1;
            if (flush) begin
                wrPtr <= '0;
                rdPtr <= '0;
                count <= '0;
            end else begin
                if (push) wrPtr <= wrPtr + 1'b1;
                if (pop)  rdPtr <= rdPtr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
            if (pop)         cur <= headEnt;
            else if (bypass) cur <= inEnt;
        end
    end

endmodule
